// File: rtl/hdu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : hdu_pkg                                                        |
// | Purpose : Shared types and constants for the HDU slot execution path.    |
// |           Slot id width, default slot count, per-slot run state and a    |
// |           saturating 32-bit counter helper.                              |
// | Ports   : none (package)                                                 |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package hdu_pkg;

  localparam int SLOT_ID_WIDTH = 3;
  localparam int NUM_SLOTS_DEF = 2**SLOT_ID_WIDTH;

  typedef enum logic [1:0] {
    SLOT_IDLE = 2'd0,
    SLOT_RUN  = 2'd1,
    SLOT_PEND = 2'd2
  } slot_state_t;

  // Add 0..3 to a 32-bit event counter, sticking at all-ones.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [1:0] inc);
    logic [32:0] sum;
    sum = {1'b0, a} + {31'd0, inc};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/slot_exec_monitor_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : rr_arbiter                                                     |
// | Purpose : Round-robin picker. Combinational grant of the first set       |
// |           request at or after the pointer; pointer moves to granted+1.   |
// | Ports   : clk, rst_n (async, active-low)                                 |
// |           req       [N]          request vector                          |
// |           gnt_valid              some request granted this cycle         |
// |           gnt_idx   [clog2(N)]   granted index                           |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module rr_arbiter #(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  output logic                 gnt_valid,
  output logic [$clog2(N)-1:0] gnt_idx
);

  localparam int c_IDX_W = $clog2(N);

  logic [c_IDX_W-1:0] r_ptr;
  logic [c_IDX_W-1:0] w_cand;

  // Scan from the farthest offset down so the nearest request to the
  // pointer is the last (winning) assignment. N is a power of two, so the
  // index wraps by truncation.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    w_cand    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      w_cand = r_ptr + c_IDX_W'(i);
      if (req[w_cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = w_cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (gnt_valid) begin
      r_ptr <= gnt_idx + c_IDX_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/slot_exec_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : slot_exec_monitor                                              |
// | Purpose : Launches compute workers on HDU dispatch, runs a per-slot      |
// |           watchdog, and returns one slot release per cycle to the HDU.   |
// | Ports   : clk, rst_n (async, active-low)                                 |
// |           dispatch_valid/dispatch_slot   launch request                  |
// |           worker_start/worker_abort      per-slot 1-cycle pulses         |
// |           worker_done                    per-slot completion pulses      |
// |           compute_done_valid/slot/tmo    slot release to HDU             |
// |           busy_vec                       slot not idle                   |
// |           cnt_completions/timeouts/errors saturating event counters      |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module slot_exec_monitor
  import hdu_pkg::*;
#(
  parameter int NUM_SLOTS      = NUM_SLOTS_DEF,
  parameter int TIMER_WIDTH    = 16,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     dispatch_valid,
  input  logic [SLOT_ID_WIDTH-1:0] dispatch_slot,
  output logic [NUM_SLOTS-1:0]     worker_start,
  output logic [NUM_SLOTS-1:0]     worker_abort,
  input  logic [NUM_SLOTS-1:0]     worker_done,
  output logic                     compute_done_valid,
  output logic [SLOT_ID_WIDTH-1:0] compute_done_slot,
  output logic                     compute_done_tmo,
  output logic [NUM_SLOTS-1:0]     busy_vec,
  output logic [31:0]              cnt_completions,
  output logic [31:0]              cnt_timeouts,
  output logic [31:0]              cnt_errors
);

  localparam logic                   c_TMO_EN     = (TIMEOUT_CYCLES != 0);
  localparam logic [TIMER_WIDTH-1:0] c_TMO_RELOAD = TIMER_WIDTH'(TIMEOUT_CYCLES);

  logic [NUM_SLOTS-1:0]     w_start_vec;
  logic [NUM_SLOTS-1:0]     w_expire_vec;
  logic [NUM_SLOTS-1:0]     w_comp_vec;
  logic [NUM_SLOTS-1:0]     w_err_disp_vec;
  logic [NUM_SLOTS-1:0]     w_err_done_vec;
  logic [NUM_SLOTS-1:0]     w_pend_vec;
  logic [NUM_SLOTS-1:0]     w_tmo_flag_vec;
  logic                     w_gnt_valid;
  logic [SLOT_ID_WIDTH-1:0] w_gnt_idx;
  logic [1:0]               w_err_inc;

  rr_arbiter #(.N(NUM_SLOTS)) u_rr_arbiter (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (w_pend_vec),
    .gnt_valid (w_gnt_valid),
    .gnt_idx   (w_gnt_idx)
  );

  for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
    slot_state_t            r_state, w_state_nxt;
    logic [TIMER_WIDTH-1:0] r_timer, w_timer_nxt;
    logic                   r_tmo, w_tmo_nxt;
    logic                   w_hit, w_granted;
    logic                   w_start, w_expire, w_comp, w_err_disp, w_err_done;

    assign w_hit     = dispatch_valid && (dispatch_slot == SLOT_ID_WIDTH'(s));
    assign w_granted = w_gnt_valid && (w_gnt_idx == SLOT_ID_WIDTH'(s));

    always_comb begin
      w_state_nxt = r_state;
      w_timer_nxt = r_timer;
      w_tmo_nxt   = r_tmo;
      w_start     = 1'b0;
      w_expire    = 1'b0;
      w_comp      = 1'b0;
      w_err_disp  = 1'b0;
      w_err_done  = 1'b0;
      case (r_state)
        SLOT_IDLE: begin
          w_err_done = worker_done[s];
          if (w_hit) begin
            w_state_nxt = SLOT_RUN;
            w_timer_nxt = c_TMO_RELOAD;
            w_start     = 1'b1;
          end
        end
        SLOT_RUN: begin
          w_err_disp = w_hit;
          // A done arriving on the expiry edge takes priority over the abort.
          if (worker_done[s]) begin
            w_state_nxt = SLOT_PEND;
            w_tmo_nxt   = 1'b0;
            w_comp      = 1'b1;
          end else if (c_TMO_EN && (r_timer == TIMER_WIDTH'(1))) begin
            w_state_nxt = SLOT_PEND;
            w_timer_nxt = '0;
            w_tmo_nxt   = 1'b1;
            w_expire    = 1'b1;
          end else if (c_TMO_EN && (r_timer != '0)) begin
            w_timer_nxt = r_timer - TIMER_WIDTH'(1);
          end
        end
        SLOT_PEND: begin
          // Still occupied on the grant edge, so a dispatch here is refused.
          w_err_disp = w_hit;
          w_err_done = worker_done[s];
          if (w_granted) begin
            w_state_nxt = SLOT_IDLE;
          end
        end
        default: begin
          w_state_nxt = SLOT_IDLE;
        end
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state <= SLOT_IDLE;
        r_timer <= '0;
        r_tmo   <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_timer <= w_timer_nxt;
        r_tmo   <= w_tmo_nxt;
      end
    end

    assign w_start_vec[s]    = w_start;
    assign w_expire_vec[s]   = w_expire;
    assign w_comp_vec[s]     = w_comp;
    assign w_err_disp_vec[s] = w_err_disp;
    assign w_err_done_vec[s] = w_err_done;
    assign w_pend_vec[s]     = (r_state == SLOT_PEND);
    assign w_tmo_flag_vec[s] = r_tmo;
    assign busy_vec[s]       = (r_state != SLOT_IDLE);
  end

  // Refused dispatch and spurious done are counted separately in one cycle.
  assign w_err_inc = {1'b0, |w_err_disp_vec} + {1'b0, |w_err_done_vec};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      worker_start       <= '0;
      worker_abort       <= '0;
      compute_done_valid <= 1'b0;
      compute_done_slot  <= '0;
      compute_done_tmo   <= 1'b0;
      cnt_completions    <= '0;
      cnt_timeouts       <= '0;
      cnt_errors         <= '0;
    end else begin
      worker_start       <= w_start_vec;
      worker_abort       <= w_expire_vec;
      compute_done_valid <= w_gnt_valid;
      compute_done_slot  <= w_gnt_valid ? w_gnt_idx : '0;
      compute_done_tmo   <= w_gnt_valid && w_tmo_flag_vec[w_gnt_idx];
      cnt_completions    <= sat_add(cnt_completions, {1'b0, |w_comp_vec});
      cnt_timeouts       <= sat_add(cnt_timeouts, {1'b0, |w_expire_vec});
      cnt_errors         <= sat_add(cnt_errors, w_err_inc);
    end
  end

endmodule
`default_nettype wire
